// File: rtl/clock_enable_scheduler.sv
// Four-channel programmable clock-enable generator. Divisor and enable updates
// go through a single config port and take effect only on a channel's period boundary.
module clock_enable_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [1:0]       i_cfg_chan,
    input  logic [WIDTH-1:0] i_cfg_div,
    input  logic             i_cfg_en,
    output logic             o_cfg_done,
    output logic             o_busy,
    output logic [3:0]       o_tick,
    output logic [3:0]       o_sq,
    output logic [3:0]       o_active
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [WIDTH-1:0] r_div [4];
    logic [WIDTH-1:0] r_cnt [4];
    logic [3:0]       r_en;
    logic [3:0]       r_tick;
    logic [3:0]       r_sq;
    logic             r_cfgDone;

    logic [1:0]       r_holdChan;
    logic [WIDTH-1:0] r_holdDiv;
    logic             r_holdEn;

    logic [3:0]       w_term;
    logic             w_accept;
    logic             w_apply;

    always_comb begin
        w_term = '0;
        for (int i = 0; i < 4; i++) begin
            w_term[i] = i_run && r_en[i] && (r_cnt[i] == '0);
        end
    end

    // A stopped target has no boundary to wait for, so the update lands at once.
    assign w_accept = i_cfg_valid && (r_state == IDLE);
    assign w_apply  = (r_state == PENDING) &&
                      (w_term[r_holdChan] || !r_en[r_holdChan] || !i_run);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = PENDING;
            PENDING: if (w_apply)  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_holdChan <= '0;
            r_holdDiv  <= '0;
            r_holdEn   <= 1'b0;
        end else if (w_accept) begin
            r_holdChan <= i_cfg_chan;
            r_holdDiv  <= i_cfg_div;
            r_holdEn   <= i_cfg_en;
        end
    end

    // The update overrides only div/en/cnt; tick and sq keep their normal
    // behaviour so a boundary tick still fires when the update lands on it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) begin
                r_div[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_en      <= '0;
            r_tick    <= '0;
            r_sq      <= '0;
            r_cfgDone <= 1'b0;
        end else begin
            r_cfgDone <= w_apply;
            for (int i = 0; i < 4; i++) begin
                if (i_run && r_en[i]) begin
                    if (r_cnt[i] == '0) begin
                        r_tick[i] <= 1'b1;
                        r_sq[i]   <= ~r_sq[i];
                        r_cnt[i]  <= r_div[i];
                    end else begin
                        r_tick[i] <= 1'b0;
                        r_cnt[i]  <= r_cnt[i] - WIDTH'(1);
                    end
                end else begin
                    r_tick[i] <= 1'b0;
                end
                if (w_apply && (r_holdChan == 2'(i))) begin
                    r_div[i] <= r_holdDiv;
                    r_en[i]  <= r_holdEn;
                    r_cnt[i] <= r_holdEn ? r_holdDiv : '0;
                end
            end
        end
    end

    assign o_cfg_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_cfg_done  = r_cfgDone;
    assign o_tick      = r_tick;
    assign o_sq        = r_sq;
    assign o_active    = r_en;

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Scoreboard bench for clock_enable_scheduler: directed config sequences push
// expected tick/cfg_done cycles, a negedge monitor pops and compares them.
module tb_clock_enable_scheduler;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic             cfgValid;
    logic             cfgReady;
    logic [1:0]       cfgChan;
    logic [WIDTH-1:0] cfgDiv;
    logic             cfgEn;
    logic             cfgDone;
    logic             busy;
    logic [3:0]       tick;
    logic [3:0]       sq;
    logic [3:0]       active;

    typedef struct {
        int cyc;
        int sq;
    } tickExp_t;

    tickExp_t tickQ [4][$];
    int       doneQ [$];
    int       winFrom [4];
    int       winTo [4];
    int       cyc = 0;
    int       vectors = 0;
    int       miscompares = 0;

    clock_enable_scheduler #(.WIDTH(WIDTH)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_run       (run),
        .i_cfg_valid (cfgValid),
        .o_cfg_ready (cfgReady),
        .i_cfg_chan  (cfgChan),
        .i_cfg_div   (cfgDiv),
        .i_cfg_en    (cfgEn),
        .o_cfg_done  (cfgDone),
        .o_busy      (busy),
        .o_tick      (tick),
        .o_sq        (sq),
        .o_active    (active)
    );

    always #5 clk = ~clk;

    // cyc is the number of rising edges so far; outputs seen at a negedge
    // were registered on edge number cyc.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushTick(input int ch, input int at, input int sqVal);
        tickExp_t e;
        e.cyc = at;
        e.sq  = sqVal;
        tickQ[ch].push_back(e);
    endtask

    task automatic setWindow(input int ch, input int from, input int to);
        winFrom[ch] = from;
        winTo[ch]   = to;
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drive one request at negedge n so it is accepted on edge n+1.
    task automatic applyStimulus(input int at, input int ch, input int div, input int en, input int doneAt);
        waitCyc(at);
        checkOutput("cfg_ready_before_request", int'(cfgReady), 1);
        cfgValid = 1'b1;
        cfgChan  = ch[1:0];
        cfgDiv   = div[WIDTH-1:0];
        cfgEn    = en[0];
        if (doneAt >= 0) doneQ.push_back(doneAt);
        @(negedge clk);
        cfgValid = 1'b0;
    endtask

    always @(negedge clk) begin
        tickExp_t e;
        int       d;
        for (int c = 0; c < 4; c++) begin
            if (tick[c] && (cyc >= winFrom[c]) && (cyc <= winTo[c])) begin
                if (tickQ[c].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_tick ch%0d: tick at cycle %0d, expected none", c, cyc);
                end else begin
                    e = tickQ[c].pop_front();
                    checkOutput($sformatf("tick%0d_cycle", c), cyc, e.cyc);
                    checkOutput($sformatf("sq%0d_at_tick", c), int'(sq[c]), e.sq);
                end
            end
        end
        if (cfgDone) begin
            if (doneQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_cfg_done: pulse at cycle %0d, expected none", cyc);
            end else begin
                d = doneQ.pop_front();
                checkOutput("cfg_done_cycle", cyc, d);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCnt;
        reset    = 1'b1;
        run      = 1'b1;
        cfgValid = 1'b0;
        cfgChan  = '0;
        cfgDiv   = '0;
        cfgEn    = 1'b0;
        for (int c = 0; c < 4; c++) setWindow(c, 1, 0);

        // Reset state after edges 1 and 2.
        waitCyc(2);
        checkOutput("reset_tick", int'(tick), 0);
        checkOutput("reset_sq", int'(sq), 0);
        checkOutput("reset_active", int'(active), 0);
        checkOutput("reset_cfg_ready", int'(cfgReady), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_cfg_done", int'(cfgDone), 0);
        reset = 1'b0;

        // ch0 div=3: applied edge 4, ticks every 4 from edge 8.
        setWindow(0, 3, 20);
        for (int c = 1; c < 4; c++) setWindow(c, 3, 24);
        pushTick(0, 8, 1);
        pushTick(0, 12, 0);
        pushTick(0, 16, 1);
        pushTick(0, 20, 0);
        applyStimulus(2, 0, 3, 1, 4);

        // ch1 div=9 then div=2 accepted with cnt=5 left after the accept edge.
        waitCyc(24);
        setWindow(1, 25, 65);
        pushTick(1, 36, 1);
        pushTick(1, 46, 0);
        pushTick(1, 56, 1);
        pushTick(1, 59, 0);
        pushTick(1, 62, 1);
        pushTick(1, 65, 0);
        applyStimulus(24, 1, 9, 1, 26);
        applyStimulus(49, 1, 2, 1, 56);
        busyCnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy) busyCnt++;
            @(negedge clk);
        end
        checkOutput("busy_cycles_ch1", busyCnt, 6);

        // ch2 div=0 ticks every cycle, then en=0 leaves one final tick.
        waitCyc(69);
        setWindow(2, 70, 90);
        for (int k = 0; k < 6; k++) pushTick(2, 72 + k, (k % 2 == 0) ? 1 : 0);
        applyStimulus(69, 2, 0, 1, 71);
        applyStimulus(75, 2, 0, 0, 77);
        waitCyc(78);
        checkOutput("active2_after_disable", int'(active[2]), 0);
        checkOutput("tick2_after_disable", int'(tick[2]), 0);

        // run=0 with a pending ch0 update: applies at once, no ticks while stopped.
        waitCyc(93);
        setWindow(0, 95, 118);
        setWindow(1, 94, 100);
        pushTick(0, 106, 1);
        pushTick(0, 112, 0);
        pushTick(0, 118, 1);
        applyStimulus(93, 0, 5, 1, 95);
        run = 1'b0;
        waitCyc(95);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("tick_while_stopped", int'(tick), 0);
        end
        run = 1'b1;

        // Reset while a ch3 update is pending drops it without cfg_done.
        waitCyc(120);
        setWindow(3, 120, 132);
        applyStimulus(120, 3, 20, 1, 122);
        applyStimulus(129, 3, 5, 1, -1);
        checkOutput("busy_while_pending", int'(busy), 1);
        waitCyc(131);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_tick", int'(tick), 0);
        checkOutput("midreset_sq", int'(sq), 0);
        checkOutput("midreset_active", int'(active), 0);
        checkOutput("midreset_cfg_ready", int'(cfgReady), 1);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_cfg_done", int'(cfgDone), 0);

        // ch1 div=255 with cfg_valid held: ch3 div=1 accepted on the cfg_done cycle.
        waitCyc(133);
        setWindow(0, 133, 647);
        setWindow(2, 133, 647);
        setWindow(1, 134, 647);
        setWindow(3, 133, 145);
        pushTick(1, 391, 1);
        pushTick(1, 647, 0);
        pushTick(3, 139, 1);
        pushTick(3, 141, 0);
        pushTick(3, 143, 1);
        pushTick(3, 145, 0);
        doneQ.push_back(135);
        doneQ.push_back(137);
        checkOutput("cfg_ready_before_b2b", int'(cfgReady), 1);
        cfgValid = 1'b1;
        cfgChan  = 2'd1;
        cfgDiv   = 8'd255;
        cfgEn    = 1'b1;
        @(negedge clk);
        cfgChan  = 2'd3;
        cfgDiv   = 8'd1;
        cfgEn    = 1'b1;
        checkOutput("busy_after_first_accept", int'(busy), 1);
        @(negedge clk);
        checkOutput("cfg_ready_on_done_cycle", int'(cfgReady), 1);
        @(negedge clk);
        cfgValid = 1'b0;
        checkOutput("busy_after_second_accept", int'(busy), 1);
        checkOutput("active1_div255", int'(active[1]), 1);

        waitCyc(650);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("tick%0d_expected_left", c), tickQ[c].size(), 0);
        end
        checkOutput("cfg_done_expected_left", doneQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_enable_scheduler.md
Name: clock_enable_scheduler

Overview:
- Four-channel programmable clock-enable generator sharing one reconfiguration port.
- Each channel is a down-counter producing a one-cycle tick every (div+1) clk cycles, plus a toggling square output at half the tick rate.
- A single-entry config FSM sequences divisor/enable updates. Updates land only on the target channel's period boundary, so no runt or stretched periods occur.
- Drives downstream logic as clock enables, replacing ripple-divided clocks.

Parameters:
- WIDTH, 8, bit width of each divisor and channel counter.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- reset  input  1  synchronous, active-high reset.
- run  input  1  global run; 0 freezes all channel counters.
- cfg_valid  input  1  config request valid.
- cfg_ready  output  1  config port idle; request accepted when cfg_valid && cfg_ready.
- cfg_chan  input  2  target channel index 0..3.
- cfg_div  input  WIDTH  new divisor; period = cfg_div+1 cycles.
- cfg_en  input  1  new channel enable.
- cfg_done  output  1  one-cycle pulse on the cycle after the update is applied.
- busy  output  1  config transaction pending (state != IDLE).
- tick  output  4  per-channel one-cycle enable pulse, registered.
- sq  output  4  per-channel square wave, toggles on each tick, registered.
- active  output  4  current per-channel enable bits.

Behaviour:
- Reset (synchronous, reset high at posedge):
  - div[i]=0, en[i]=0, cnt[i]=0, tick=0, sq=0, cfg_done=0, state=IDLE.
  - Any pending transaction is dropped without cfg_done.
- cfg_ready = (state==IDLE), combinational; busy = ~cfg_ready; active = en.
- Channel i, per posedge, with run=1 and en[i]=1:
  - If cnt[i]==0: tick[i]<=1, sq[i]<=~sq[i], cnt[i]<=div[i].
  - Else: tick[i]<=0, cnt[i]<=cnt[i]-1.
- Channel i with en[i]=0 or run=0: tick[i]<=0, cnt[i] and sq[i] hold.
- div=0 gives tick high every cycle; div=2^WIDTH-1 gives period 2^WIDTH. The counter never underflows.
- "Terminal" for channel i = run && en[i] && cnt[i]==0 on that edge.
- Config FSM states: IDLE, PENDING.
- IDLE:
  - On cfg_valid && cfg_ready, capture chan/div/en into holding regs and go to PENDING.
  - No channel is modified on the accept edge, even if the target is terminal on that same edge.
- PENDING: apply on the first edge where any of these holds: the target is terminal, en[target]=0, or run=0. Then:
  - div[t]<=hold_div, en[t]<=hold_en, cfg_done<=1, state<=IDLE.
  - Applied at terminal: the boundary tick and sq toggle still occur. If hold_en=1, cnt[t]<=hold_div, so the new period starts immediately. If hold_en=0, cnt[t]<=0 and the channel stops after this final tick.
  - Applied while disabled or run=0, with hold_en=1: cnt[t]<=hold_div, no tick, sq unchanged. First tick comes hold_div+1 running cycles later.
  - Applied while disabled or run=0, with hold_en=0: cnt[t]<=0, no tick.
- cfg_done is high exactly one cycle. cfg_ready returns high in that same cycle, so back-to-back accept is allowed on the cfg_done cycle.
- Latency from accept edge to apply edge is 1..old_div+1 cycles while running and enabled.
- Non-target channels are never disturbed by config activity.
- cfg_chan/cfg_div/cfg_en are don't-care unless cfg_valid && cfg_ready.

Test Plan:
- Reset, then configure ch0 div=3 en=1 with run=1 -> cfg_done 1 cycle after accept. tick[0] first high 4 cycles later, then every 4 cycles. sq[0] period 8. Other ticks stay 0.
- ch1 running div=9. Accept div=2 at cnt[1]=5 -> busy high 6 cycles. Apply on the terminal edge with that tick present. Next ticks at +3, +6. No period of length other than 10 or 3.
- ch2 div=0 en=1 -> tick[2] constant 1 and sq[2] toggles every cycle. Then cfg en=0 -> one final tick, then tick[2]=0, active[2]=0.
- run=0 with ch0 enabled and a pending update to ch0 -> update applies on next edge, cfg_done pulses, no ticks while run=0. run=1 -> first tick after new div+1 cycles.
- Assert reset while PENDING with ch3 mid-count -> next cycle all outputs 0, cfg_ready=1, no cfg_done. A new request is accepted normally.
- div=255 (WIDTH=8) on ch1 -> tick period exactly 256 cycles, no wrap glitch. cfg_valid held high continuously -> second request accepted on the cfg_done cycle.
